// File: rtl/mac_pe_vec.sv
// mac_pe_vec: LANES-wide signed dot-product MAC PE with operand forwarding; define MAC_SAT_EN to saturate on overflow
module mac_pe_vec #(
  parameter int W = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic                 clear,
  input  logic                 last,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic [LANES*W-1:0]   a_out,
  output logic [LANES*W-1:0]   b_out,
  output logic                 valid_out,
  output logic [ACC_W-1:0]     c_out,
  output logic                 c_valid,
  output logic                 ovf
);
  logic [LANES-1:0][2*W-1:0] prod, p;
  logic signed [ACC_W-1:0] sum, s, acc, add, acc_nxt;
  logic v1, clr1, last1, v2, clr2, last2, ovf_add;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod[i] = $signed(a[i*W +: W]) * $signed(b[i*W +: W]);
  end
  always_comb begin
    sum = '0;
    for (int j = 0; j < LANES; j++) sum = sum + ACC_W'($signed(p[j]));
  end
  assign add = acc + s;
  assign ovf_add = (acc[ACC_W-1] == s[ACC_W-1]) && (add[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_SAT_EN
  assign acc_nxt = ovf_add ? (s[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : add;
`else
  assign acc_nxt = add;
`endif
  assign c_out = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      valid_out <= 1'b0;
      p <= '0;
      v1 <= 1'b0;
      clr1 <= 1'b0;
      last1 <= 1'b0;
      s <= '0;
      v2 <= 1'b0;
      clr2 <= 1'b0;
      last2 <= 1'b0;
      acc <= '0;
      c_valid <= 1'b0;
      ovf <= 1'b0;
    end else if (en) begin
      a_out <= a;
      b_out <= b;
      valid_out <= valid_in;
      p <= prod;
      v1 <= valid_in;
      clr1 <= clear;
      last1 <= last;
      s <= sum;
      v2 <= v1;
      clr2 <= clr1;
      last2 <= last1;
      acc <= v2 ? (clr2 ? s : acc_nxt) : (clr2 ? '0 : acc);
      c_valid <= v2 & last2;
      ovf <= v2 ? (!clr2 && (ovf || ovf_add)) : ovf;
    end
  end
endmodule

// File: tb/tb_mac_pe_vec.sv
// tb_mac_pe_vec: directed table and sequence checks for mac_pe_vec
module tb_mac_pe_vec;
  logic clk = 1'b0;
  logic rst, en, valid_in, clear, last;
  logic [63:0] a, b, a_out, b_out, a_out2, b_out2;
  logic valid_out, c_valid, ovf, valid_out2, c_valid2, ovf2;
  logic [39:0] c_out;
  logic [33:0] c_out2;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic v, c, l;
    logic [63:0] a, b;
    longint ec;
    logic ecv;
  } vec_t;
  vec_t tbl[15];
  localparam int M = -32768;
`ifdef MAC_SAT_EN
  localparam longint OVF_EXP = 64'sd8589934591;
`else
  localparam longint OVF_EXP = -64'sd8589934592;
`endif
  always #5 clk = ~clk;
  mac_pe_vec u_dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .clear(clear), .last(last),
    .a(a), .b(b), .a_out(a_out), .b_out(b_out), .valid_out(valid_out),
    .c_out(c_out), .c_valid(c_valid), .ovf(ovf)
  );
  mac_pe_vec #(.ACC_W(34)) u_ovf (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .clear(clear), .last(last),
    .a(a), .b(b), .a_out(a_out2), .b_out(b_out2), .valid_out(valid_out2),
    .c_out(c_out2), .c_valid(c_valid2), .ovf(ovf2)
  );
  function automatic logic [63:0] pk(int x0, int x1, int x2, int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction
  task automatic chk(string n, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic drive(logic v, logic c, logic l, logic [63:0] aa, logic [63:0] bb);
    valid_in = v;
    clear = c;
    last = l;
    a = aa;
    b = bb;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    drive(0, 0, 0, '0, '0);
  endtask
  initial begin
    tbl[0]  = '{1, 1, 1, pk(10, -5, 7, -8), pk(3, 4, -6, -8), 0, 0};
    tbl[1]  = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 0, 0};
    tbl[2]  = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 32, 1};
    tbl[3]  = '{1, 1, 0, pk(1, 1, 1, 1), pk(1, 2, 3, 4), 32, 0};
    tbl[4]  = '{1, 0, 0, pk(1, 1, 1, 1), pk(1, 2, 3, 4), 32, 0};
    tbl[5]  = '{1, 0, 1, pk(1, 1, 1, 1), pk(1, 2, 3, 4), 10, 0};
    tbl[6]  = '{1, 1, 1, pk(2, 0, 0, 0), pk(5, 0, 0, 0), 20, 0};
    tbl[7]  = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 30, 1};
    tbl[8]  = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 10, 1};
    tbl[9]  = '{0, 0, 1, pk(3, 3, 3, 3), pk(3, 3, 3, 3), 10, 0};
    tbl[10] = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 10, 0};
    tbl[11] = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 10, 0};
    tbl[12] = '{0, 1, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 10, 0};
    tbl[13] = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 10, 0};
    tbl[14] = '{0, 0, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 0, 0};
    rst = 1'b1;
    en = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      en = (i == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom});
      tick();
    end
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_c_out", $signed(c_out), 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    en = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_c_valid", c_valid, 0);
    end
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].a, tbl[i].b);
      tick();
      chk($sformatf("tbl%0d_a_out", i), a_out, tbl[i].a);
      chk($sformatf("tbl%0d_b_out", i), b_out, tbl[i].b);
      chk($sformatf("tbl%0d_valid_out", i), valid_out, tbl[i].v);
      chk($sformatf("tbl%0d_c_out", i), $signed(c_out), tbl[i].ec);
      chk($sformatf("tbl%0d_c_valid", i), c_valid, tbl[i].ecv);
    end
    drive(1, 1, 0, pk(1, 1, 1, 1), pk(1, 2, 3, 4));
    tick();
    chk("stall_b1_c_out", $signed(c_out), 0);
    drive(1, 0, 0, pk(1, 1, 1, 1), pk(1, 2, 3, 4));
    tick();
    chk("stall_b2_c_out", $signed(c_out), 0);
    en = 1'b0;
    drive(1, 1, 1, pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_hold_c_out", $signed(c_out), 0);
      chk("stall_hold_a_out", a_out, pk(1, 1, 1, 1));
      chk("stall_hold_c_valid", c_valid, 0);
    end
    en = 1'b1;
    drive(1, 0, 1, pk(1, 1, 1, 1), pk(1, 2, 3, 4));
    tick();
    chk("stall_b3_c_out", $signed(c_out), 10);
    idle();
    tick();
    chk("stall_s2_c_out", $signed(c_out), 20);
    chk("stall_s2_c_valid", c_valid, 0);
    tick();
    chk("stall_s3_c_out", $signed(c_out), 30);
    chk("stall_s3_c_valid", c_valid, 1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_cv_hold_c_valid", c_valid, 1);
      chk("stall_cv_hold_c_out", $signed(c_out), 30);
    end
    en = 1'b1;
    tick();
    chk("stall_release_c_valid", c_valid, 0);
    chk("stall_release_c_out", $signed(c_out), 30);
    drive(1, 1, 0, pk(M, M, M, M), pk(M, M, M, M));
    tick();
    drive(1, 0, 1, pk(M, M, M, M), pk(M, M, M, M));
    tick();
    idle();
    tick();
    chk("ovf_load_c_out", $signed(c_out2), 64'sd4294967296);
    chk("ovf_load_ovf", ovf2, 0);
    tick();
    chk("ovf_c_out", $signed(c_out2), OVF_EXP);
    chk("ovf_flag", ovf2, 1);
    chk("ovf_c_valid", c_valid2, 1);
    chk("wide_c_out", $signed(c_out), 64'sd8589934592);
    chk("wide_ovf", ovf, 0);
    drive(1, 1, 0, pk(0, 0, 0, 0), pk(0, 0, 0, 0));
    tick();
    idle();
    tick();
    chk("ovf_sticky", ovf2, 1);
    tick();
    chk("ovf_cleared", ovf2, 0);
    chk("ovf_cleared_c_out", $signed(c_out2), 0);
    drive(1, 1, 0, pk(M, M, M, M), pk(M, M, M, M));
    tick();
    drive(1, 0, 0, pk(M, M, M, M), pk(M, M, M, M));
    tick();
    idle();
    tick();
    tick();
    chk("mid_ovf_set", ovf2, 1);
    drive(1, 1, 1, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_c_valid", c_valid, 0);
      chk("mid_rst_c_valid_ovf_dut", c_valid2, 0);
    end
    chk("mid_rst_c_out", $signed(c_out), 0);
    chk("mid_rst_c_out_ovf_dut", $signed(c_out2), 0);
    chk("mid_rst_ovf", ovf2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_pe_vec.md
Name: mac_pe_vec

Overview:
Parametrised successor to the scalar systolic MAC processing element. Each cycle it takes LANES signed operand pairs, multiplies them and reduces the products to one lane sum. The sum is added into a single accumulator through a 3-stage pipeline. Operands are forwarded one cycle later to the neighbouring PE. Valid/clear/last tags travel with the data, so a result pulse marks each completed dot product.

Parameters:
W, 16, signed operand width per lane
LANES, 4, operand pairs per cycle (power of two, >=1)
ACC_W, 40, accumulator width; must be >= 2*W + clog2(LANES)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  global advance; low = whole block holds (stall)
valid_in  input  1  operand vector valid
clear  input  1  start new accumulation with this beat
last  input  1  final beat of current dot product
a  input  LANES*W  packed signed operands, lane i at [i*W +: W]
b  input  LANES*W  packed signed operands
a_out  output  LANES*W  registered copy of a
b_out  output  LANES*W  registered copy of b
valid_out  output  1  registered copy of valid_in
c_out  output  ACC_W  signed accumulator value
c_valid  output  1  one-cycle pulse: c_out holds a completed dot product
ovf  output  1  sticky overflow flag

Behaviour:
- Reset: sync, active-high, one clk edge. All outputs and internal pipeline registers go to 0. rst has priority over en. A reset mid-operation discards every in-flight beat; no c_valid follows for them.
- en=0: every register holds, including the forwarding regs, the pipeline tags, c_out, c_valid and ovf. c_valid therefore stays high across a stall if it was high.
- Forwarding: with en=1, a_out/b_out/valid_out <= a/b/valid_in every edge (regardless of valid_in). Latency 1.
- Stage 1 (edge k): per-lane product p_i = a_i*b_i, full 2W signed. Register tags v1, clr1, last1 <= valid_in, clear, last.
- Stage 2 (edge k+1): s = sum of p_i, sign-extended to ACC_W. Tags shift.
- Stage 3 (edge k+2): accumulator update, decided by the stage-2 tags:
  - v2=1, clr2=1: acc <= s (load, not add).
  - v2=1, clr2=0: acc <= acc + s.
  - v2=0, clr2=1: acc <= 0 (bubble clear).
  - v2=0, clr2=0: acc holds.
- c_out = acc. It is visible the cycle after edge k+2, i.e. 3 edges after the input was sampled.
- c_valid <= v2 & last2 at edge k+2. It is a single-cycle pulse unless stalled. last without valid has no effect.
- Overflow: without the optional feature, the add wraps in two's complement; ovf is set on signed overflow of acc + s and is cleared only by rst or by a valid clear beat reaching stage 3.
- Back-to-back: a new clear/valid beat may directly follow a last beat. No bubble is required and throughput is 1 beat/cycle.

Optional Feature:
MAC_SAT_EN
- Defined: on signed overflow, acc saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and ovf is set. A load (clear) beat never saturates.
- Undefined: wrap-around as in Behaviour; ovf still reports overflow.

Test Plan:
- Reset: rst=1 for 2 edges with random a/b/valid_in -> all outputs 0, c_valid=0. No c_valid appears for 3 cycles after rst deasserts.
- Single beat, LANES=4: a={10,-5,7,-8}, b={3,4,-6,-8}, valid/clear/last=1 -> a_out/b_out match after 1 edge; c_out=32 and c_valid=1 for exactly one cycle, 3 edges after sampling.
- Multi-beat: beat1 a={1,1,1,1}, b={1,2,3,4} with clear; beat2 same without clear; beat3 same with last -> c_out sequence 10, 20, 30; c_valid only with 30. An immediate next beat with clear, a={2,0,0,0}, b={5,0,0,0}, last -> 10 with c_valid.
- Stall: repeat the multi-beat test with en=0 for 2 cycles after beat2 -> identical values; c_valid arrives 2 cycles later and stays high while en=0 if stalled on it.
- Overflow, ACC_W=34: two beats of all lanes a=b=-32768 (s=2^32), clear on first, last on second -> with MAC_SAT_EN c_out=8589934591; without it c_out=-8589934592. ovf=1 in both builds, and it clears on the next clear beat.
- Reset mid-stream: assert rst one edge after a last beat enters -> no c_valid, c_out=0, ovf=0.
